// File: rtl/sid_cfg_ctrl_pkg.sv
// Shared types and constants for the SID configuration controller (package sid).
// Holds the config record, state encoding, unlock key and register offsets.
package sid;

   typedef enum logic {
      MOS6581 = 1'b0,
      MOS8580 = 1'b1
   } model_e;

   // bit 0 is never stored in the shadow map, so only even encodings exist
   typedef enum logic [2:0] {
      D400 = 3'd0,
      D500 = 3'd2,
      DE00 = 3'd4,
      DF00 = 3'd6
   } addr_e;

   typedef struct packed {
      model_e             model;
      addr_e              addr;
      logic [8:0]         fc_base;
      logic signed [10:0] fc_offset;
   } cfg_t;

   localparam int PHI2_RISE = 0;
   localparam int PHI1_PHI2 = 1;
   localparam int PHI2_FALL = 2;
   localparam int PHI2_PHI1 = 3;
   typedef logic [3:0] phase_t;

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      OPEN    = 2'd1,
      PENDING = 2'd2
   } cfg_ctrl_state_e;

   localparam logic [4:0][7:0] CFG_KEY = {8'h50, 8'h49, 8'h44, 8'h45, 8'h52};
   localparam logic [7:0] CFG_CMD_COMMIT = 8'h43;
   localparam logic [7:0] CFG_CMD_LOCK   = 8'h4C;
   localparam logic [4:0] CFG_REG_INDEX  = 5'h1D;
   localparam logic [4:0] CFG_REG_DATA   = 5'h1E;
   localparam logic [4:0] CFG_REG_KEY    = 5'h1F;

   function automatic logic [7:0] cfg_byte(input cfg_t c, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = {4'b0000, c.fc_base[8], c.addr[2:1], c.model};
         2'd1:    b = c.fc_base[7:0];
         2'd2:    b = c.fc_offset[7:0];
         2'd3:    b = {5'b00000, c.fc_offset[10:8]};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic cfg_t cfg_write(input cfg_t c, input logic [1:0] sel,
                                      input logic [7:0] d, input logic addr_lock);
      cfg_t r;
      r = c;
      case (sel)
         2'd0: begin
            r.model      = model_e'(d[0]);
            r.fc_base[8] = d[3];
            if (!addr_lock) r.addr = addr_e'({d[2:1], 1'b0});
            else            r.addr = c.addr;
         end
         2'd1:    r.fc_base[7:0]    = d;
         2'd2:    r.fc_offset[7:0]  = d;
         2'd3:    r.fc_offset[10:8] = d[2:0];
         default: r = c;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sid_cfg_ctrl_if.sv
// Register bus between the CPU-side decoder and the SID configuration controller.
interface sid_cfg_ctrl_if;
   logic       cs;
   logic       we;
   logic [4:0] addr;
   logic [7:0] data_i;
   logic [7:0] data_o;
   logic       data_oe;

   modport master (output cs, we, addr, data_i, input data_o, data_oe);
   modport slave  (input cs, we, addr, data_i, output data_o, data_oe);
endinterface

// File: rtl/sid_cfg_ctrl_unlock.sv
// Tracks progress through the 5-byte unlock key; match_done flags the final correct byte.
module sid_cfg_unlock
   import sid::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       key_we,
   input  logic [7:0] key_byte,
   output logic       match_done
);

   logic [2:0] progress_r;
   logic [2:0] progress_nxt_s;
   logic       hit_s;

   assign hit_s      = (key_byte == CFG_KEY[progress_r]);
   assign match_done = key_we & hit_s & (progress_r == 3'd4);

   // next progress: advance on a hit, restart (counting a fresh 'R') on a miss
   always_comb begin
      progress_nxt_s = progress_r;
      if (clr || match_done) begin
         progress_nxt_s = 3'd0;
      end else if (key_we) begin
         if (hit_s)                   progress_nxt_s = progress_r + 3'd1;
         else if (key_byte == CFG_KEY[0]) progress_nxt_s = 3'd1;
         else                         progress_nxt_s = 3'd0;
      end else begin
         progress_nxt_s = progress_r;
      end
   end

   // progress register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) progress_r <= 3'd0;
      else        progress_r <= progress_nxt_s;
   end

endmodule

// File: rtl/sid_cfg_ctrl.sv
// Keyed configuration controller for two SID cores; shadow edits commit when pipelines idle.
// Optional readback of the shadow map is built when SID_CFG_READBACK_EN is defined.
module sid_cfg_ctrl
   import sid::*;
#(
   parameter cfg_t SID1_CFG_DEFAULT = '{MOS6581, D400, 9'd250, 11'sd0},
   parameter cfg_t SID2_CFG_DEFAULT = '{MOS8580, DE00, 9'd250, 11'sd0},
   parameter int   TIMEOUT_BITS     = 16
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  phase_t                phase,
   sid_cfg_ctrl_if.slave         bus,
   input  logic                  pipe_idle,
   output cfg_t                  sid1_cfg,
   output cfg_t                  sid2_cfg,
   output logic                  commit_o,
   output logic                  open_o
);

   localparam logic [TIMEOUT_BITS-1:0] TMR_MAX = '1;

   cfg_ctrl_state_e           state_r, state_nxt_s;
   logic [2:0]                index_r, index_nxt_s;
   cfg_t                      shadow1_r, shadow1_nxt_s;
   cfg_t                      shadow2_r, shadow2_nxt_s;
   cfg_t                      cfg1_r, cfg1_nxt_s;
   cfg_t                      cfg2_r, cfg2_nxt_s;
   logic [TIMEOUT_BITS-1:0]   timer_r, timer_nxt_s;
   logic                      commit_r, commit_nxt_s;
   logic                      open_r;
   logic                      wr_s, wr_idx_s, wr_data_s, wr_key_s;
   logic                      accept_s, tick_s, expired_s, match_done_s;
   logic                      unused_phase_s;

   assign wr_s      = bus.cs & bus.we;
   assign wr_idx_s  = wr_s & (bus.addr == CFG_REG_INDEX);
   assign wr_data_s = wr_s & (bus.addr == CFG_REG_DATA);
   assign wr_key_s  = wr_s & (bus.addr == CFG_REG_KEY);
   assign tick_s    = phase[PHI1_PHI2];
   assign unused_phase_s = ^phase;

   sid_cfg_unlock u_unlock (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (state_r != LOCKED),
      .key_we     (wr_key_s & (state_r == LOCKED)),
      .key_byte   (bus.data_i),
      .match_done (match_done_s)
   );

   // inactivity timer: cleared by accepted writes in OPEN, saturates so PENDING can defer the lock
   always_comb begin
      accept_s    = (state_r == OPEN) & (wr_idx_s | wr_data_s | wr_key_s);
      timer_nxt_s = timer_r;
      if (state_r == LOCKED || accept_s) begin
         timer_nxt_s = '0;
      end else if (tick_s && timer_r != TMR_MAX) begin
         timer_nxt_s = timer_r + 1'b1;
      end else begin
         timer_nxt_s = timer_r;
      end
      expired_s = (timer_nxt_s == TMR_MAX);
   end

   // state machine, shadow edits and commit
   always_comb begin
      state_nxt_s   = state_r;
      index_nxt_s   = index_r;
      shadow1_nxt_s = shadow1_r;
      shadow2_nxt_s = shadow2_r;
      cfg1_nxt_s    = cfg1_r;
      cfg2_nxt_s    = cfg2_r;
      commit_nxt_s  = 1'b0;
      case (state_r)
         LOCKED: begin
            if (match_done_s) begin
               state_nxt_s   = OPEN;
               index_nxt_s   = 3'd0;
               shadow1_nxt_s = cfg1_r;
               shadow2_nxt_s = cfg2_r;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         OPEN: begin
            if (wr_idx_s) begin
               index_nxt_s = bus.data_i[2:0];
            end else if (wr_data_s) begin
               if (index_r[2]) shadow2_nxt_s = cfg_write(shadow2_r, index_r[1:0], bus.data_i, 1'b0);
               else            shadow1_nxt_s = cfg_write(shadow1_r, index_r[1:0], bus.data_i, 1'b1);
               index_nxt_s = index_r + 3'd1;
            end else if (wr_key_s) begin
               if (bus.data_i == CFG_CMD_COMMIT)    state_nxt_s = PENDING;
               else if (bus.data_i == CFG_CMD_LOCK) state_nxt_s = LOCKED;
               else                                 state_nxt_s = OPEN;
            end else if (expired_s) begin
               state_nxt_s = LOCKED;
            end else begin
               state_nxt_s = OPEN;
            end
         end
         PENDING: begin
            if (pipe_idle) begin
               cfg1_nxt_s   = shadow1_r;
               cfg2_nxt_s   = shadow2_r;
               commit_nxt_s = 1'b1;
               state_nxt_s  = expired_s ? LOCKED : OPEN;
            end else begin
               state_nxt_s = PENDING;
            end
         end
         default: begin
            state_nxt_s = LOCKED;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= LOCKED;
         index_r   <= 3'd0;
         shadow1_r <= SID1_CFG_DEFAULT;
         shadow2_r <= SID2_CFG_DEFAULT;
         cfg1_r    <= SID1_CFG_DEFAULT;
         cfg2_r    <= SID2_CFG_DEFAULT;
         timer_r   <= '0;
         commit_r  <= 1'b0;
         open_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         index_r   <= index_nxt_s;
         shadow1_r <= shadow1_nxt_s;
         shadow2_r <= shadow2_nxt_s;
         cfg1_r    <= cfg1_nxt_s;
         cfg2_r    <= cfg2_nxt_s;
         timer_r   <= (state_nxt_s == LOCKED) ? '0 : timer_nxt_s;
         commit_r  <= commit_nxt_s;
         open_r    <= (state_nxt_s != LOCKED);
      end
   end

   assign sid1_cfg = cfg1_r;
   assign sid2_cfg = cfg2_r;
   assign commit_o = commit_r;
   assign open_o   = open_r;

`ifdef SID_CFG_READBACK_EN
   assign bus.data_oe = bus.cs & (bus.addr == CFG_REG_DATA) & open_r;
   assign bus.data_o  = index_r[2] ? cfg_byte(shadow2_r, index_r[1:0])
                                   : cfg_byte(shadow1_r, index_r[1:0]);
`else
   assign bus.data_oe = 1'b0;
   assign bus.data_o  = 8'h00;
`endif

endmodule

// File: tb/tb_sid_cfg_ctrl.sv
// Directed self-checking bench for sid_cfg_ctrl (TIMEOUT_BITS=4).
module tb_sid_cfg_ctrl;
   import sid::*;

   localparam logic [4:0] A_IDX = 5'h1D;
   localparam logic [4:0] A_DAT = 5'h1E;
   localparam logic [4:0] A_KEY = 5'h1F;
`ifdef SID_CFG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst_n;
   phase_t phase;
   logic   pipe_idle;
   cfg_t   sid1_cfg, sid2_cfg;
   logic   commit_o, open_o;
   int     n_pass = 0;
   int     n_total = 0;
   logic [7:0] rb_d;
   logic       rb_oe;

   sid_cfg_ctrl_if bus ();

   sid_cfg_ctrl #(.TIMEOUT_BITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .phase     (phase),
      .bus       (bus),
      .pipe_idle (pipe_idle),
      .sid1_cfg  (sid1_cfg),
      .sid2_cfg  (sid2_cfg),
      .commit_o  (commit_o),
      .open_o    (open_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
      @(negedge clk);
      bus.cs = 1'b0; bus.we = 1'b0;
   endtask

   task automatic rd(output logic [7:0] d, output logic oe);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b0; bus.addr = A_DAT;
      #1;
      d = bus.data_o; oe = bus.data_oe;
      @(negedge clk);
      bus.cs = 1'b0;
   endtask

   task automatic unlock();
      wr(A_KEY, 8'h52); wr(A_KEY, 8'h45); wr(A_KEY, 8'h44); wr(A_KEY, 8'h49); wr(A_KEY, 8'h50);
   endtask

   task automatic tick(input phase_t p);
      @(negedge clk); phase = p;
      @(negedge clk); phase = 4'b0000;
   endtask

   initial begin
      rst_n = 1'b0; phase = 4'b0000; pipe_idle = 1'b0;
      bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 5'h00; bus.data_i = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_sid1", sid1_cfg, {1'b0, 3'd0, 9'd250, 11'h000});
      chk("rst_sid2", sid2_cfg, {1'b1, 3'd4, 9'd250, 11'h000});
      chk("rst_open", open_o, 1'b0);
      chk("rst_commit", commit_o, 1'b0);
      chk("rst_oe", bus.data_oe, 1'b0);
      chk("rst_do", bus.data_o, 8'h00);
      rst_n = 1'b1;

      // wrong last byte, then restart on a stray 'R'
      wr(A_KEY, 8'h52); wr(A_KEY, 8'h45); wr(A_KEY, 8'h44); wr(A_KEY, 8'h49); wr(A_KEY, 8'h58);
      chk("redix", open_o, 1'b0);
      wr(A_KEY, 8'h52); wr(A_KEY, 8'h45);
      unlock();
      chk("rere_dip", open_o, 1'b1);
      wr(A_KEY, 8'h58);
      chk("open_other_key", open_o, 1'b1);
      wr(A_KEY, 8'h4C);
      chk("lock_cmd", open_o, 1'b0);
      // 'R' on a non-key offset must not count
      wr(5'h10, 8'h52); wr(A_KEY, 8'h45); wr(A_KEY, 8'h44); wr(A_KEY, 8'h49); wr(A_KEY, 8'h50);
      chk("ignored_offset", open_o, 1'b0);

      unlock();
      chk("reopen", open_o, 1'b1);
      wr(A_IDX, 8'h00);
      wr(A_DAT, 8'h07); wr(A_DAT, 8'hFA); wr(A_DAT, 8'hF6); wr(A_DAT, 8'h07);
      wr(A_DAT, 8'h0D);
      wr(A_IDX, 8'h05); wr(A_DAT, 8'h2C);
      chk("no_early_sid1", sid1_cfg, {1'b0, 3'd0, 9'd250, 11'h000});
      chk("no_early_sid2", sid2_cfg, {1'b1, 3'd4, 9'd250, 11'h000});

      // commit held off while pipelines busy; writes in PENDING ignored
      wr(A_KEY, 8'h43);
      wr(A_DAT, 8'hFF);
      wr(A_IDX, 8'h00);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("pend_no_commit", commit_o, 1'b0);
      end
      chk("pend_sid2", sid2_cfg, {1'b1, 3'd4, 9'd250, 11'h000});
      chk("pend_open", open_o, 1'b1);
      pipe_idle = 1'b1;
      @(negedge clk);
      chk("commit_pulse", commit_o, 1'b1);
      chk("commit_sid1", sid1_cfg, {1'b1, 3'd0, 9'd250, 11'h7F6});
      chk("commit_sid2", sid2_cfg, {1'b1, 3'd4, 9'd300, 11'h000});
      chk("commit_open", open_o, 1'b1);
      @(negedge clk);
      chk("commit_single", commit_o, 1'b0);

      // index wrap 7 -> 0, SID #1 address stays D400
      wr(A_IDX, 8'h07); wr(A_DAT, 8'h05); wr(A_DAT, 8'h03);
      wr(A_IDX, 8'h07);
      rd(rb_d, rb_oe);
      chk("rb_oe", rb_oe, RB);
      chk("rb_idx7", rb_d, RB ? 8'h05 : 8'h00);
      rd(rb_d, rb_oe);
      chk("rb_noadv", rb_d, RB ? 8'h05 : 8'h00);
      wr(A_IDX, 8'h00);
      rd(rb_d, rb_oe);
      chk("rb_idx0", rb_d, RB ? 8'h01 : 8'h00);

      // 'C' accepted with pipe_idle already high: commit one cycle later
      wr(A_KEY, 8'h43);
      chk("lat_no_commit", commit_o, 1'b0);
      @(negedge clk);
      chk("lat_commit", commit_o, 1'b1);
      chk("wrap_sid2", sid2_cfg, {1'b1, 3'd4, 9'd300, 11'h500});
      chk("wrap_sid1", sid1_cfg, {1'b1, 3'd0, 9'd250, 11'h7F6});
      @(negedge clk);
      pipe_idle = 1'b0;

      // inactivity timeout: only the PHI1_PHI2 bit counts
      tick(4'b1101); tick(4'b1101);
      for (int i = 0; i < 14; i++) tick(4'b0010);
      chk("tmo_14", open_o, 1'b1);
      tick(4'b0010);
      chk("tmo_15", open_o, 1'b0);

      // timeout while PENDING is deferred until the commit
      unlock();
      wr(A_IDX, 8'h02); wr(A_DAT, 8'h00);
      wr(A_KEY, 8'h43);
      for (int i = 0; i < 20; i++) tick(4'b0010);
      chk("ptmo_open", open_o, 1'b1);
      chk("ptmo_nocommit", commit_o, 1'b0);
      pipe_idle = 1'b1;
      @(negedge clk);
      chk("ptmo_commit", commit_o, 1'b1);
      chk("ptmo_sid1", sid1_cfg, {1'b1, 3'd0, 9'd250, 11'h700});
      chk("ptmo_locked", open_o, 1'b0);
      @(negedge clk);
      pipe_idle = 1'b0;

      // reset while PENDING discards the commit
      unlock();
      wr(A_IDX, 8'h04); wr(A_DAT, 8'h00);
      wr(A_KEY, 8'h43);
      chk("rstp_open", open_o, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstp_sid1", sid1_cfg, {1'b0, 3'd0, 9'd250, 11'h000});
      chk("rstp_sid2", sid2_cfg, {1'b1, 3'd4, 9'd250, 11'h000});
      chk("rstp_open0", open_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; pipe_idle = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstp_no_commit", commit_o, 1'b0);
      end
      chk("rstp_sid2_after", sid2_cfg, {1'b1, 3'd4, 9'd250, 11'h000});
      chk("rstp_locked", open_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sid_cfg_ctrl.md
SID_CFG_CTRL -- requirements
Module: sid_cfg_ctrl

Interface
REQ-001 SHALL have parameter SID1_CFG_DEFAULT, default {MOS6581, D400, 9'd250, 11'sd0}, SID #1 config after reset.
REQ-002 SHALL have parameter SID2_CFG_DEFAULT, default {MOS8580, DE00, 9'd250, 11'sd0}, SID #2 config after reset.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 16, width of the inactivity timer in phi2 cycles.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1 (system clock); rst_n input 1 (asynchronous active-low reset).
REQ-005 phase  input  sid::phase_t  one-hot SID core clock phase; phase[sid::PHI1_PHI2] is the per-phi2 tick.
REQ-006 cs  input  1  decoded SID #1 chip select; we  input  1  one-cycle write strobe; addr  input  5  register offset; data_i  input  8  write data.
REQ-007 pipe_idle  input  1  voice/filter pipelines idle, so config may change.
REQ-008 sid1_cfg, sid2_cfg  output  sid::cfg_t  active configurations; commit_o  output  1  one-cycle pulse when configs update.
REQ-009 open_o  output  1  config interface unlocked; data_o  output  8  readback data; data_oe  output  1  readback valid.

Function
REQ-010 SHALL act only on writes with cs=1, we=1 to offsets 0x1D (INDEX), 0x1E (DATA) and 0x1F (KEY); other writes SHALL be ignored.
REQ-011 State machine SHALL have states LOCKED, OPEN and PENDING; LOCKED tracks unlock progress 0..4.
REQ-012 LOCKED: KEY writes of 0x52,0x45,0x44,0x49,0x50 ("REDIP") in order SHALL advance progress; the fifth SHALL enter OPEN with index=0 and shadow copied from the active configs.
REQ-013 LOCKED: a wrong KEY byte SHALL reset progress to 0, or to 1 if the byte is 0x52.
REQ-014 OPEN: an INDEX write SHALL set index=data_i[2:0]; a DATA write SHALL write shadow[index], then index+1, wrapping 7->0.
REQ-015 Shadow map per SID n (base n*4): +0 {model[0], addr[2:1], fc_base[8] at bit 3}; +1 fc_base[7:0]; +2 fc_offset[7:0]; +3 fc_offset[10:8] in bits [2:0]. Unused bits SHALL read 0. SID #1 addr SHALL read D400 and ignore writes.
REQ-016 OPEN: KEY 0x43 ('C') SHALL enter PENDING; KEY 0x4C ('L') SHALL enter LOCKED; other KEY bytes SHALL be ignored.
REQ-017 PENDING: INDEX/DATA/KEY writes SHALL be ignored; on the first clk with pipe_idle=1, shadow SHALL load into sid1_cfg/sid2_cfg at that edge, commit_o SHALL pulse for that cycle, and the state SHALL return to OPEN.
REQ-018 If pipe_idle=1 on the same edge the 'C' write is accepted, the commit SHALL occur on the next edge (latency 1 cycle minimum).
REQ-019 Inactivity timer SHALL clear on every accepted INDEX/DATA/KEY write and increment on each phase tick while OPEN; on reaching 2**TIMEOUT_BITS-1 the state SHALL become LOCKED.
REQ-020 A timeout during PENDING SHALL be deferred: the commit SHALL complete, then the state SHALL become LOCKED.
REQ-021 open_o SHALL be 1 in OPEN and PENDING.

Reset
REQ-022 On rst_n=0: state LOCKED, progress 0, index 0, timer 0, sid1_cfg=SID1_CFG_DEFAULT, sid2_cfg=SID2_CFG_DEFAULT, commit_o=0, open_o=0, data_o=0, data_oe=0.
REQ-023 Reset during PENDING SHALL discard the pending commit; active configs SHALL return to their defaults.

Configuration
REQ-024 With SID_CFG_READBACK_EN defined: data_oe SHALL be cs & (addr==0x1E) & open_o, and data_o SHALL be shadow[index], combinational; reads SHALL NOT advance index.
REQ-025 Without SID_CFG_READBACK_EN: data_oe and data_o SHALL be constant 0, and no readback logic SHALL be built.

Structure
REQ-026 Package sid SHALL hold cfg_ctrl_state_e, CFG_KEY (5-byte unlock key), CFG_CMD_COMMIT=0x43, CFG_CMD_LOCK=0x4C, and offsets CFG_REG_INDEX/DATA/KEY.
REQ-027 Key matching SHALL be a sub-module sid_cfg_unlock (progress counter; outputs match_done).

Verification
REQ-028 Reset -> sid1_cfg={6581,D400,250,0}, sid2_cfg={8580,DE00,250,0}, open_o=0.
REQ-029 KEY "REDIP" -> open_o=1; KEY "RERDIP" -> open_o=1 (restart on 0x52); KEY "REDIX" -> open_o=0.
REQ-030 Open; INDEX=5, DATA=0x2C; KEY 'C' with pipe_idle=0 for 10 cycles -> no change; pipe_idle=1 -> sid2 fc_base=300 (0x12C, bit 8 already 1 from default 250? no: 250=0x0FA, so bit 8 set via INDEX=4 DATA=0x08 first), commit_o single pulse.
REQ-031 Open, INDEX=7, DATA twice -> second write lands at index 0; readback (with macro) returns the written bytes.
REQ-032 Open with TIMEOUT_BITS=4 and no writes -> LOCKED after 15 ticks; same with 'C' pending and pipe_idle=0 -> stays PENDING, commits when idle, then LOCKED.
REQ-033 rst_n pulled low in PENDING -> configs return to defaults, commit_o never pulses.
